// File: rtl/debug_dump_tx.sv
// debug_dump_tx: serialises a debug snapshot (PC, register file and, optionally,
// data memory) into a byte frame for a UART TX FIFO.
// Frame: 0xA5, PC, registers, [memory words], XOR checksum.
// Multi-byte words are sent most significant byte first.
// Build option: define DEBUG_DUMP_MEM_EN to include the data memory section.
module debug_dump_tx #(
    parameter int unsigned SIZE          = 32,
    parameter int unsigned NUM_REGISTERS = 32,
    parameter int unsigned MEM_SIZE      = 64,
    parameter int unsigned ADDR_WIDTH    = $clog2(MEM_SIZE)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [SIZE-1:0]               i_pc,
    input  logic [NUM_REGISTERS*SIZE-1:0] i_registers_debug,
    output logic [ADDR_WIDTH-1:0]         o_debug_addr,
    input  logic [SIZE-1:0]               i_debug_data,
    input  logic                          i_tx_full,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int unsigned REG_IDX_W = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PC,
        REGS,
        CHECKSUM,
        DONE
`ifdef DEBUG_DUMP_MEM_EN
        ,
        MEM_ADDR,
        MEM_BYTES
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [REG_IDX_W-1:0]   reg_idx_q, reg_idx_d;
    logic [31:0]            pc_snap_q, pc_snap_d;
    logic [7:0]             checksum_q, checksum_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   sent;

`ifdef DEBUG_DUMP_MEM_EN
    logic [ADDR_WIDTH-1:0]  mem_idx_q, mem_idx_d;
    logic [31:0]            mem_word_q, mem_word_d;
    logic                   mem_wait_q, mem_wait_d;
    logic [ADDR_WIDTH-1:0]  debug_addr_q, debug_addr_d;
`else
    logic                   unused_debug_data;
`endif

    // Unpacked view of the flattened register file
    logic [SIZE-1:0] reg_words [NUM_REGISTERS];

    for (genvar k = 0; k < NUM_REGISTERS; k++) begin : g_reg_words
        assign reg_words[k] = i_registers_debug[k*SIZE +: SIZE];
    end

    // Select byte idx of a word, idx 0 being the most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{~idx, 3'b000} +: 8];
    endfunction

    // State register and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            reg_idx_q    <= '0;
            pc_snap_q    <= '0;
            checksum_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
`ifdef DEBUG_DUMP_MEM_EN
            mem_idx_q    <= '0;
            mem_word_q   <= '0;
            mem_wait_q   <= 1'b0;
            debug_addr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            reg_idx_q    <= reg_idx_d;
            pc_snap_q    <= pc_snap_d;
            checksum_q   <= checksum_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
`ifdef DEBUG_DUMP_MEM_EN
            mem_idx_q    <= mem_idx_d;
            mem_word_q   <= mem_word_d;
            mem_wait_q   <= mem_wait_d;
            debug_addr_q <= debug_addr_d;
`endif
        end
    end

    // Next-state logic; the byte for the state being entered is preloaded into tx_data
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        reg_idx_d    = reg_idx_q;
        pc_snap_d    = pc_snap_q;
        checksum_d   = checksum_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tx_valid_d   = 1'b0;
        tx_data_d    = 8'h00;
`ifdef DEBUG_DUMP_MEM_EN
        mem_idx_d    = mem_idx_q;
        mem_word_d   = mem_word_q;
        mem_wait_d   = 1'b0;
        debug_addr_d = debug_addr_q;
`endif
        sent         = tx_valid_q && !i_tx_full;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = HEADER;
                    pc_snap_d  = 32'(i_pc);
                    checksum_d = 8'h00;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    reg_idx_d  = '0;
`ifdef DEBUG_DUMP_MEM_EN
                    mem_idx_d  = '0;
`endif
                end
            end
            HEADER: begin
                if (sent) begin
                    state_d    = PC;
                    byte_idx_d = '0;
                end
            end
            PC: begin
                if (sent) begin
                    checksum_d = checksum_q ^ tx_data_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = REGS;
                    end
                end
            end
            REGS: begin
                if (sent) begin
                    checksum_d = checksum_q ^ tx_data_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (reg_idx_q == REG_IDX_W'(NUM_REGISTERS - 1)) begin
                            reg_idx_d = '0;
`ifdef DEBUG_DUMP_MEM_EN
                            state_d   = MEM_ADDR;
                            mem_idx_d = '0;
`else
                            state_d   = CHECKSUM;
`endif
                        end else begin
                            reg_idx_d = reg_idx_q + REG_IDX_W'(1);
                        end
                    end
                end
            end
`ifdef DEBUG_DUMP_MEM_EN
            MEM_ADDR: begin
                // First cycle lets the synchronous memory read; second latches it
                if (!mem_wait_q) begin
                    mem_wait_d = 1'b1;
                end else begin
                    mem_word_d = 32'(i_debug_data);
                    byte_idx_d = '0;
                    state_d    = MEM_BYTES;
                end
            end
            MEM_BYTES: begin
                if (sent) begin
                    checksum_d = checksum_q ^ tx_data_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (mem_idx_q == ADDR_WIDTH'(MEM_SIZE - 1)) begin
                            state_d = CHECKSUM;
                        end else begin
                            mem_idx_d = mem_idx_q + ADDR_WIDTH'(1);
                            state_d   = MEM_ADDR;
                        end
                    end
                end
            end
`endif
            CHECKSUM: begin
                if (sent) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Byte offered to the FIFO in the next cycle; held unchanged while stalled
        case (state_d)
            HEADER: begin
                tx_valid_d = 1'b1;
                tx_data_d  = HEADER_BYTE;
            end
            PC: begin
                tx_valid_d = 1'b1;
                tx_data_d  = word_byte(pc_snap_d, byte_idx_d);
            end
            REGS: begin
                tx_valid_d = 1'b1;
                tx_data_d  = word_byte(32'(reg_words[reg_idx_d]), byte_idx_d);
            end
`ifdef DEBUG_DUMP_MEM_EN
            MEM_BYTES: begin
                tx_valid_d = 1'b1;
                tx_data_d  = word_byte(mem_word_d, byte_idx_d);
            end
`endif
            CHECKSUM: begin
                tx_valid_d = 1'b1;
                tx_data_d  = checksum_d;
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase

`ifdef DEBUG_DUMP_MEM_EN
        if (state_d == MEM_ADDR) begin
            debug_addr_d = mem_idx_d;
        end
`endif
    end

    // The write strobe is qualified by the live FIFO-full flag so no byte is written into a full FIFO
    assign o_tx_start = tx_valid_q & ~i_tx_full;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

`ifdef DEBUG_DUMP_MEM_EN
    assign o_debug_addr = debug_addr_q;
`else
    assign o_debug_addr      = '0;
    assign unused_debug_data = ^i_debug_data;
`endif

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 SHALL have parameter SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter NUM_REGISTERS, default 32, register file depth.
REQ-003 SHALL have parameter MEM_SIZE, default 64, data memory depth in words.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_SIZE), data memory address width.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit, reset; asynchronous, active-high.
REQ-007 SHALL have port i_start, input, 1 bit, one-cycle request to begin a dump.
REQ-008 SHALL have port i_pc, input, SIZE bits, current program counter.
REQ-009 SHALL have port i_registers_debug, input, NUM_REGISTERS*SIZE bits, flattened register file; register k is in bits [k*SIZE +: SIZE].
REQ-010 SHALL have port o_debug_addr, output, ADDR_WIDTH bits, data memory debug read address.
REQ-011 SHALL have port i_debug_data, input, SIZE bits, data memory debug read data, valid one cycle after o_debug_addr changes.
REQ-012 SHALL have port i_tx_full, input, 1 bit, UART TX FIFO full.
REQ-013 SHALL have port o_tx_data, output, 8 bits, byte to be written to the UART TX FIFO.
REQ-014 SHALL have port o_tx_start, output, 1 bit, one-cycle FIFO write strobe qualifying o_tx_data.
REQ-015 SHALL have port o_busy, output, 1 bit, high from acceptance of i_start until o_done.
REQ-016 SHALL have port o_done, output, 1 bit, one-cycle pulse when the dump completes.

Function
REQ-017 SHALL implement the states IDLE, HEADER, PC, REGS, MEM_ADDR, MEM_BYTES, CHECKSUM and DONE.
REQ-018 SHALL, in IDLE, accept i_start, capture i_pc into an internal snapshot, clear the checksum, and move to HEADER.
REQ-019 SHALL ignore i_start whenever o_busy is high.
REQ-020 SHALL emit frame bytes in this order: 0xA5; PC snapshot (4 bytes); registers 0..NUM_REGISTERS-1 (4 bytes each); memory words 0..MEM_SIZE-1 (4 bytes each); checksum (1 byte).
REQ-021 SHALL transmit every 32-bit word most significant byte first.
REQ-022 SHALL assert o_tx_start for exactly one cycle per byte, and only in a cycle where i_tx_full is low.
REQ-023 SHALL hold the state, byte index and o_tx_data while i_tx_full is high, and resume on the first cycle it is low, with no byte lost or duplicated.
REQ-024 SHALL sample i_registers_debug live; the caller holds the register file stable while o_busy is high.
REQ-025 SHALL, in MEM_ADDR, drive o_debug_addr with the word index and wait one cycle, then latch i_debug_data and move to MEM_BYTES.
REQ-026 SHALL return from MEM_BYTES to MEM_ADDR with the index incremented, or go to CHECKSUM after index MEM_SIZE-1; the index SHALL NOT wrap.
REQ-027 SHALL compute the checksum as the XOR of every byte sent after 0xA5 and before the checksum byte.
REQ-028 SHALL enter DONE after the checksum strobe, pulse o_done for one cycle, drop o_busy in that same cycle, and return to IDLE.
REQ-029 SHALL give a total frame length of 390 bytes with default parameters and DUMP_MEM_EN defined.
REQ-030 SHALL produce the first o_tx_start no earlier than 1 cycle after i_start is accepted.

Reset
REQ-031 SHALL, while i_rst is high, force: state IDLE, o_tx_start 0, o_tx_data 0x00, o_busy 0, o_done 0, o_debug_addr 0, checksum 0, all counters 0.
REQ-032 SHALL, when reset is asserted mid-dump, abort immediately, issue no further strobes, and not pulse o_done.

Configuration
REQ-033 SHALL honour the macro DEBUG_DUMP_MEM_EN: when it is defined, the memory section is included; when it is undefined, REGS goes directly to CHECKSUM, MEM_ADDR and MEM_BYTES are not built, o_debug_addr is tied to 0, and the frame is 134 bytes.

Verification
REQ-034 SHALL cover: reset, i_pc=0x00400010, register k=k, memory word k=0x1000+k, i_start pulse, i_tx_full=0 -> 390 strobes; bytes A5 00 40 00 10 00 00 00 00 ...; final byte equals the XOR of the body; o_done pulses once.
REQ-035 SHALL cover: i_tx_full held high for 5 cycles during the register section -> no strobes during the stall; the byte stream is identical to the unstalled run.
REQ-036 SHALL cover: a second i_start at byte 50 -> ignored; exactly one frame and one o_done.
REQ-037 SHALL cover: i_rst asserted at byte 200 -> o_tx_start=0 and o_busy=0 immediately, no o_done; a new i_start afterwards produces a complete frame starting with 0xA5.
REQ-038 SHALL cover: build without DEBUG_DUMP_MEM_EN, all registers 0xFFFFFFFF, i_pc=0 -> 134 bytes; o_debug_addr stays 0; checksum byte 0x00.
